// File: rtl/mp3_pc_niosii_cpu_ocimem_pkg.sv
// Shared constants and types for the Nios II on-chip debug memory stage:
// jdo field positions, default geometry and the single-port RAM grant encoding.
package mp3_pc_niosii_ocimem_pkg;

    localparam int OCIMEM_RAM_AW     = 8;
    localparam int OCIMEM_PROT_WORDS = 64;

    localparam int JDO_ADDR_HI = 33;
    localparam int JDO_ADDR_LO = 26;
    localparam int JDO_CLR_ERR = 25;
    localparam int JDO_RD      = 17;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_JTAG_RD,
        GNT_JTAG_WR,
        GNT_AV_RD,
        GNT_AV_WR
    } gnt_e;

    function automatic logic gnt_is_jtag(input gnt_e g);
        return (g == GNT_JTAG_RD) || (g == GNT_JTAG_WR);
    endfunction

endpackage

// File: rtl/mp3_pc_niosii_cpu_ocimem_if.sv
// Avalon-MM debug memory slave bundle; the CPU side drives master, the ocimem stage is slave.
// Reads return one cycle after acceptance; av_waitrequest stalls a request while JTAG owns the RAM.
interface mp3_pc_niosii_cpu_ocimem_if #(
    parameter int AW = 8
);
    logic [AW-1:0] av_address;
    logic          av_read;
    logic          av_write;
    logic [3:0]    av_byteenable;
    logic [31:0]   av_writedata;
    logic          debugaccess;
    logic          av_waitrequest;
    logic [31:0]   av_readdata;
    logic          av_readdatavalid;

    modport master (
        output av_address, av_read, av_write, av_byteenable, av_writedata, debugaccess,
        input  av_waitrequest, av_readdata, av_readdatavalid
    );

    modport slave (
        input  av_address, av_read, av_write, av_byteenable, av_writedata, debugaccess,
        output av_waitrequest, av_readdata, av_readdatavalid
    );

endinterface

// File: rtl/mp3_pc_niosii_cpu_ocimem_ram.sv
// Single-port synchronous debug RAM with byte enables; read data registered, 1-cycle latency.
// No backpressure: one access per cycle when en_i is high. Contents are never reset.
module mp3_pc_niosii_cpu_ocimem_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   q_o
);

    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                q_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/mp3_pc_niosii_cpu_ocimem.sv
// JTAG/Avalon debug memory stage: strobe to monitor_ready in 2 cycles, Avalon read data 1 cycle after accept.
// A pending JTAG access always wins the RAM; Avalon stalls on av_waitrequest. NIOSII_OCIMEM_ROM_PROTECT_EN drops non-debug top-region writes.
module mp3_pc_niosii_cpu_ocimem
    import mp3_pc_niosii_ocimem_pkg::*;
#(
    parameter int RAM_AW     = OCIMEM_RAM_AW,
    parameter int PROT_WORDS = OCIMEM_PROT_WORDS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [37:0]               jdo,
    input  logic                      take_action_ocimem_a,
    input  logic                      take_no_action_ocimem_a,
    input  logic                      take_action_ocimem_b,
    mp3_pc_niosii_cpu_ocimem_if.slave av,
    output logic [31:0]               MonDReg,
    output logic                      monitor_ready,
    output logic                      monitor_error
);

    localparam int DEPTH = 2**RAM_AW;
    localparam logic [RAM_AW-1:0] PROT_BASE = RAM_AW'(DEPTH - PROT_WORDS);

    logic [RAM_AW-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wr_pend_q, wr_pend_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              jrd_fl_q, jrd_fl_d;
    logic              jwr_fl_q, jwr_fl_d;
    logic              avrd_fl_q, avrd_fl_d;
    logic [31:0]       av_rdata_q, av_rdata_d;

    gnt_e              gnt;
    logic              strobe, jtag_pend;
    logic              av_in_prot, av_drop;
    logic              ram_en, ram_we;
    logic [3:0]        ram_be;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_q;
    logic [31:0]       jdo_data;
    logic              unused_ok;

    assign strobe    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign jtag_pend = rd_pend_q | wr_pend_q;
    assign jdo_data  = jdo[JDO_DATA_HI:JDO_DATA_LO];
    assign av_in_prot = (av.av_address >= PROT_BASE);

`ifdef NIOSII_OCIMEM_ROM_PROTECT_EN
    assign av_drop   = av_in_prot & ~av.debugaccess;
    assign unused_ok = ^{jdo[37:35], jdo[2:0]};
`else
    assign av_drop   = 1'b0;
    assign unused_ok = ^{jdo[37:35], jdo[2:0], av.debugaccess, av_in_prot};
`endif

    // Grants are suppressed in reset so a pending access never reaches the RAM.
    always_comb begin
        gnt = GNT_NONE;
        if (reset_n) begin
            if (rd_pend_q)        gnt = GNT_JTAG_RD;
            else if (wr_pend_q)   gnt = GNT_JTAG_WR;
            else if (av.av_read)  gnt = GNT_AV_RD;
            else if (av.av_write) gnt = GNT_AV_WR;
        end
    end

    assign av.av_waitrequest = jtag_pend & (av.av_read | av.av_write);

    assign ram_en    = (gnt != GNT_NONE);
    assign ram_we    = (gnt == GNT_JTAG_WR) || (gnt == GNT_AV_WR);
    assign ram_addr  = gnt_is_jtag(gnt) ? mon_a_q : av.av_address;
    assign ram_wdata = (gnt == GNT_JTAG_WR) ? wr_data_q : av.av_writedata;
    assign ram_be    = (gnt == GNT_JTAG_WR) ? 4'hF : (av.av_byteenable & {4{~av_drop}});

    mp3_pc_niosii_cpu_ocimem_ram #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .q_o     (ram_q)
    );

    always_comb begin
        mon_a_d    = mon_a_q;
        mon_d_d    = mon_d_q;
        rdy_d      = rdy_q;
        err_d      = err_q;
        rd_pend_d  = rd_pend_q;
        wr_pend_d  = wr_pend_q;
        wr_data_d  = wr_data_q;
        jrd_fl_d   = (gnt == GNT_JTAG_RD);
        jwr_fl_d   = (gnt == GNT_JTAG_WR);
        avrd_fl_d  = (gnt == GNT_AV_RD);
        av_rdata_d = avrd_fl_q ? ram_q : av_rdata_q;

        if (jrd_fl_q) begin
            mon_d_d = ram_q;
            rdy_d   = 1'b1;
        end
        if (jwr_fl_q) begin
            rdy_d = 1'b1;
        end

        if (gnt == GNT_JTAG_RD) begin
            rd_pend_d = 1'b0;
        end
        if (gnt == GNT_JTAG_WR) begin
            wr_pend_d = 1'b0;
            mon_a_d   = mon_a_q + RAM_AW'(1);
        end

        // A new strobe overrides anything above: it replaces the pending access and wins MonAReg.
        if (strobe && jtag_pend) begin
            err_d = 1'b1;
        end
        if (take_action_ocimem_a) begin
            mon_a_d   = RAM_AW'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
            rdy_d     = 1'b0;
            rd_pend_d = jdo[JDO_RD];
            wr_pend_d = 1'b0;
            if (jdo[JDO_CLR_ERR]) begin
                err_d = 1'b0;
            end
        end else if (take_no_action_ocimem_a) begin
            mon_a_d   = mon_a_q + RAM_AW'(1);
            rd_pend_d = 1'b1;
            wr_pend_d = 1'b0;
        end else if (take_action_ocimem_b) begin
            wr_pend_d = 1'b1;
            rd_pend_d = 1'b0;
            wr_data_d = jdo_data;
            mon_d_d   = jdo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mon_a_q    <= '0;
            mon_d_q    <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= '0;
            jrd_fl_q   <= 1'b0;
            jwr_fl_q   <= 1'b0;
            avrd_fl_q  <= 1'b0;
            av_rdata_q <= '0;
        end else begin
            mon_a_q    <= mon_a_d;
            mon_d_q    <= mon_d_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            rd_pend_q  <= rd_pend_d;
            wr_pend_q  <= wr_pend_d;
            wr_data_q  <= wr_data_d;
            jrd_fl_q   <= jrd_fl_d;
            jwr_fl_q   <= jwr_fl_d;
            avrd_fl_q  <= avrd_fl_d;
            av_rdata_q <= av_rdata_d;
        end
    end

    assign av.av_readdatavalid = avrd_fl_q;
    assign av.av_readdata      = avrd_fl_q ? ram_q : av_rdata_q;
    assign MonDReg             = mon_d_q;
    assign monitor_ready       = rdy_q;
    assign monitor_error       = err_q;

endmodule

// File: tb/tb_mp3_pc_niosii_cpu_ocimem.sv
// Bench for the debug memory stage: directed scenarios plus a random op sequence
// checked against a transaction-level memory/monitor model.
module tb_mp3_pc_niosii_cpu_ocimem;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int PROT  = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    mp3_pc_niosii_cpu_ocimem_if #(.AW(AW)) av_if ();

    mp3_pc_niosii_cpu_ocimem #(.RAM_AW(AW), .PROT_WORDS(PROT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_no_action_ocimem_a (tna_a),
        .take_action_ocimem_b    (ta_b),
        .av                      (av_if),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_mem [DEPTH];
    logic [7:0]  m_a;
    logic [31:0] m_d;
    logic        m_rdy, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mon(input string tag);
        chk({tag, "_mondreg"}, MonDReg, m_d);
        chk({tag, "_ready"}, 32'(monitor_ready), 32'(m_rdy));
        chk({tag, "_error"}, 32'(monitor_error), 32'(m_err));
    endtask

    function automatic logic prot_drop(input logic [7:0] a, input logic dbg);
`ifdef NIOSII_OCIMEM_ROM_PROTECT_EN
        return (int'(a) >= DEPTH - PROT) && !dbg;
`else
        return 1'b0;
`endif
    endfunction

    task automatic jtag_addr(input logic [7:0] a, input logic rd, input logic clr);
        jdo = '0;
        jdo[33:26] = a;
        jdo[25] = clr;
        jdo[17] = rd;
        ta_a = 1'b1;
        tick();
        ta_a = 1'b0;
        jdo = '0;
        m_a = a;
        m_rdy = 1'b0;
        if (clr) m_err = 1'b0;
        tick();
        chk("addr_ready_early", 32'(monitor_ready), 32'd0);
        tick();
        if (rd) begin
            m_d = m_mem[a];
            m_rdy = 1'b1;
        end
        chk_mon("addr");
    endtask

    task automatic jtag_rdahead();
        tna_a = 1'b1;
        tick();
        tna_a = 1'b0;
        m_a = m_a + 8'd1;
        tick();
        tick();
        m_d = m_mem[m_a];
        m_rdy = 1'b1;
        chk_mon("rdahead");
    endtask

    task automatic jtag_wr(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        ta_b = 1'b1;
        tick();
        ta_b = 1'b0;
        jdo = '0;
        chk("wr_echo", MonDReg, d);
        m_d = d;
        tick();
        tick();
        m_mem[m_a] = d;
        m_a = m_a + 8'd1;
        m_rdy = 1'b1;
        chk_mon("wr");
    endtask

    task automatic av_wait();
        int w = 0;
        #1;
        while (av_if.av_waitrequest && w < 8) begin
            tick();
            w++;
        end
        chk("av_wait_bound", 32'(av_if.av_waitrequest), 32'd0);
    endtask

    task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
        av_if.av_address = a;
        av_if.av_writedata = d;
        av_if.av_byteenable = be;
        av_if.debugaccess = dbg;
        av_if.av_write = 1'b1;
        av_wait();
        tick();
        av_if.av_write = 1'b0;
        if (!prot_drop(a, dbg)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic av_rd(input logic [7:0] a, input string tag);
        av_if.av_address = a;
        av_if.av_read = 1'b1;
        av_wait();
        tick();
        av_if.av_read = 1'b0;
        chk({tag, "_valid"}, 32'(av_if.av_readdatavalid), 32'd1);
        chk({tag, "_data"}, av_if.av_readdata, m_mem[a]);
        tick();
        chk({tag, "_valid_drop"}, 32'(av_if.av_readdatavalid), 32'd0);
        chk({tag, "_hold"}, av_if.av_readdata, m_mem[a]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        av_if.av_address = '0;
        av_if.av_read = 1'b0;
        av_if.av_write = 1'b0;
        av_if.av_byteenable = '0;
        av_if.av_writedata = '0;
        av_if.debugaccess = 1'b0;

        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        m_a = '0; m_d = '0; m_rdy = 1'b0; m_err = 1'b0;
        chk_mon("reset");
        chk("reset_rdvalid", 32'(av_if.av_readdatavalid), 32'd0);
        chk("reset_waitreq", 32'(av_if.av_waitrequest), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            av_wr(8'(i), $urandom, 4'hF, 1'b1);
        end

        jtag_addr(8'h10, 1'b0, 1'b0);
        jtag_wr(32'hDEADBEEF);
        jtag_addr(8'h10, 1'b1, 1'b0);
        chk("wb_readback", MonDReg, 32'hDEADBEEF);

        av_wr(8'hFF, 32'hFFFF0000, 4'hF, 1'b1);
        av_wr(8'h00, 32'h0000A5A5, 4'hF, 1'b1);
        jtag_addr(8'hFF, 1'b1, 1'b0);
        jtag_rdahead();
        chk("wrap_data", MonDReg, 32'h0000A5A5);

        jdo = '0; jdo[33:26] = 8'h30; jdo[17] = 1'b1;
        ta_a = 1'b1;
        tick();
        jdo = '0; jdo[33:26] = 8'h31; jdo[17] = 1'b1;
        tick();
        ta_a = 1'b0;
        jdo = '0;
        chk("overrun_error", 32'(monitor_error), 32'd1);
        tick();
        tick();
        m_a = 8'h31; m_d = m_mem[8'h31]; m_rdy = 1'b1; m_err = 1'b1;
        chk_mon("overrun");
        jtag_addr(8'h40, 1'b0, 1'b1);
        chk("overrun_cleared", 32'(monitor_error), 32'd0);

        jtag_addr(8'h10, 1'b0, 1'b0);
        d = $urandom;
        jdo = '0; jdo[34:3] = d;
        ta_b = 1'b1;
        tick();
        ta_b = 1'b0;
        jdo = '0;
        av_if.av_address = 8'h10;
        av_if.av_read = 1'b1;
        #1;
        chk("cont_wait_hi", 32'(av_if.av_waitrequest), 32'd1);
        tick();
        chk("cont_wait_lo", 32'(av_if.av_waitrequest), 32'd0);
        tick();
        av_if.av_read = 1'b0;
        m_mem[8'h10] = d; m_a = 8'h11; m_d = d; m_rdy = 1'b1;
        chk("cont_valid", 32'(av_if.av_readdatavalid), 32'd1);
        chk("cont_data", av_if.av_readdata, d);
        chk_mon("cont");
        tick();
        chk("cont_valid_drop", 32'(av_if.av_readdatavalid), 32'd0);
        chk("cont_hold", av_if.av_readdata, d);

        av_wr(8'hC0, 32'h0BADF00D, 4'hF, 1'b1);
        av_wr(8'hC0, 32'h12345678, 4'hF, 1'b0);
        av_rd(8'hC0, "prot_dbg0");
        av_wr(8'hC0, 32'h12345678, 4'hF, 1'b1);
        av_rd(8'hC0, "prot_dbg1");
        chk("prot_dbg1_val", av_if.av_readdata, 32'h12345678);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 4))
                0: jtag_addr(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                1: jtag_rdahead();
                2: jtag_wr($urandom);
                3: av_wr(8'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
                default: av_rd(8'($urandom), "rnd_rd");
            endcase
        end

        jdo = '0; jdo[33:26] = 8'h22; jdo[17] = 1'b1;
        ta_a = 1'b1;
        tick();
        ta_a = 1'b0;
        jdo = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_a = '0; m_d = '0; m_rdy = 1'b0; m_err = 1'b0;
        chk_mon("rst_mid");
        chk("rst_mid_rdvalid", 32'(av_if.av_readdatavalid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_mon("rst_after");
        end
        jtag_rdahead();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
